// File: rtl/qr_job_scheduler.sv
// Job scheduler for the pipelined QR core: buffers H matrices, issues one per core
// accept slot, tracks jobs with a shadow valid/tag pipe and registers tagged Q/R results.
module qr_job_scheduler #(
    parameter int DEPTH      = 4,
    parameter int QR_LATENCY = 6,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [255:0]     in_H,
    output logic             qr_enable,
    output logic             qr_accept_in,
    input  logic             qr_accept_out,
    input  logic             qr_ready_out,
    output logic [255:0]     qr_H,
    input  logic [255:0]     qr_Q,
    input  logic [255:0]     qr_R,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [255:0]     res_Q,
    output logic [255:0]     res_R,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy,
    output logic             err_sync
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready never depends on valid of the same interface, valid holds until accepted.

    logic [255:0]     fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             issue;
    logic             stall;
    logic             load;
    logic [TAG_W-1:0] tag_cnt;
    logic [QR_LATENCY-1:0] sh_valid;
    logic [TAG_W-1:0] sh_tag [QR_LATENCY];

    assign full         = (count == (AW+1)'(DEPTH));
    assign empty        = (count == '0);
    assign in_ready     = !full;
    assign push         = in_valid && !full;
    assign stall        = res_valid && !res_ready;
    assign qr_enable    = !stall;
    assign qr_accept_in = qr_enable;
    assign issue        = qr_enable && qr_accept_out && !empty;
    assign qr_H         = issue ? fifo_mem[rd_ptr] : '0;
    assign load         = qr_enable && sh_valid[QR_LATENCY-1];
    assign busy         = !empty || (|sh_valid) || res_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_H;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tag_cnt <= tag_cnt + 1'b1;
            end
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Shadow pipe mirrors the core's enabled-cycle pipeline; bubbles carry tag 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_valid <= '0;
            for (int i = 0; i < QR_LATENCY; i++) begin
                sh_tag[i] <= '0;
            end
        end else if (qr_enable) begin
            sh_valid[0] <= issue;
            sh_tag[0]   <= issue ? tag_cnt : '0;
            for (int i = 1; i < QR_LATENCY; i++) begin
                sh_valid[i] <= sh_valid[i-1];
                sh_tag[i]   <= sh_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_Q     <= '0;
            res_R     <= '0;
            res_tag   <= '0;
            err_sync  <= 1'b0;
        end else begin
            if (load) begin
                res_valid <= 1'b1;
                res_Q     <= qr_Q;
                res_R     <= qr_R;
                res_tag   <= sh_tag[QR_LATENCY-1];
                if (!qr_ready_out) begin
                    err_sync <= 1'b1;
                end
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qr_job_scheduler.sv
// Bench for qr_job_scheduler: ideal core model, job-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_qr_job_scheduler;

    localparam int DEPTH = 4;
    localparam int LAT   = 6;
    localparam int TAG_W = 4;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [255:0]     in_H;
    logic             qr_enable;
    logic             qr_accept_in;
    logic             qr_accept_out;
    logic             qr_ready_out;
    logic [255:0]     qr_H;
    logic [255:0]     qr_Q;
    logic [255:0]     qr_R;
    logic             res_valid;
    logic             res_ready;
    logic [255:0]     res_Q;
    logic [255:0]     res_R;
    logic [TAG_W-1:0] res_tag;
    logic             busy;
    logic             err_sync;

    logic             force_nr;
    int               n_pass;
    int               n_checks;
    int               cyc;
    int               push_stalls;
    logic [TAG_W-1:0] exp_q [$];
    logic [TAG_W-1:0] acc_q [$];
    int               acc_cyc [$];

    qr_job_scheduler #(.DEPTH(DEPTH), .QR_LATENCY(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_H(in_H),
        .qr_enable(qr_enable), .qr_accept_in(qr_accept_in),
        .qr_accept_out(qr_accept_out), .qr_ready_out(qr_ready_out),
        .qr_H(qr_H), .qr_Q(qr_Q), .qr_R(qr_R),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_Q(res_Q), .res_R(res_R), .res_tag(res_tag),
        .busy(busy), .err_sync(err_sync)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] f_q(input logic [255:0] h);
        return ~h;
    endfunction

    function automatic logic [255:0] f_r(input logic [255:0] h);
        return {h[127:0], h[255:128]};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- ideal core model ----------------
    logic         core_v [LAT];
    logic [255:0] core_h [LAT];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) begin
                core_v[i] <= 1'b0;
                core_h[i] <= '0;
            end
        end else if (qr_enable) begin
            core_v[0] <= qr_accept_out;
            core_h[0] <= qr_H;
            for (int i = 1; i < LAT; i++) begin
                core_v[i] <= core_v[i-1];
                core_h[i] <= core_h[i-1];
            end
        end
    end

    assign qr_ready_out = core_v[LAT-1] && !force_nr;
    assign qr_Q         = f_q(core_h[LAT-1]);
    assign qr_R         = f_r(core_h[LAT-1]);

    // ---------------- job-level reference model ----------------
    typedef struct {
        logic [255:0]     h;
        logic [TAG_W-1:0] tag;
        int               cnt;
    } job_t;

    logic [255:0]     m_fifo [$];
    job_t             m_jobs [$];
    job_t             m_j;
    logic [TAG_W-1:0] m_tag;
    logic             m_res_valid;
    logic [255:0]     m_res_q;
    logic [255:0]     m_res_r;
    logic [TAG_W-1:0] m_res_tag;
    logic             m_err;
    logic             m_en;
    logic             m_iss;
    logic             m_full;
    logic             m_load;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_fifo.delete();
            m_jobs.delete();
            m_tag       = '0;
            m_res_valid = 1'b0;
            m_res_q     = '0;
            m_res_r     = '0;
            m_res_tag   = '0;
            m_err       = 1'b0;
        end else begin
            m_en   = !(m_res_valid && !res_ready);
            m_iss  = m_en && qr_accept_out && (m_fifo.size() > 0);
            m_full = (m_fifo.size() == DEPTH);
            m_load = 1'b0;
            if (m_en) begin
                foreach (m_jobs[i]) m_jobs[i].cnt--;
                if (m_jobs.size() > 0 && m_jobs[0].cnt == 0) begin
                    m_j       = m_jobs.pop_front();
                    m_load    = 1'b1;
                    m_res_q   = f_q(m_j.h);
                    m_res_r   = f_r(m_j.h);
                    m_res_tag = m_j.tag;
                    if (!qr_ready_out) m_err = 1'b1;
                end
                if (m_iss) begin
                    m_j.h   = m_fifo.pop_front();
                    m_j.tag = m_tag;
                    m_j.cnt = LAT;
                    m_jobs.push_back(m_j);
                    m_tag   = m_tag + 1'b1;
                end
            end
            if (m_load) m_res_valid = 1'b1;
            else if (res_ready) m_res_valid = 1'b0;
            if (in_valid && !m_full) m_fifo.push_back(in_H);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic         c_en;
    logic         c_iss;
    logic [255:0] c_h;

    always @(negedge clk) begin
        if (reset_n) begin
            c_en  = !(m_res_valid && !res_ready);
            c_iss = c_en && qr_accept_out && (m_fifo.size() > 0);
            c_h   = c_iss ? m_fifo[0] : '0;
            chk("in_ready", in_ready, m_fifo.size() < DEPTH);
            chk("qr_enable", qr_enable, c_en);
            chk("qr_accept_in", qr_accept_in, c_en);
            chk("qr_H", qr_H, c_h);
            chk("res_valid", res_valid, m_res_valid);
            chk("res_Q", res_Q, m_res_q);
            chk("res_R", res_R, m_res_r);
            chk("res_tag", res_tag, m_res_tag);
            chk("busy", busy, (m_fifo.size() > 0) || (m_jobs.size() > 0) || m_res_valid);
            chk("err_sync", err_sync, m_err);
        end
    end

    // Accepted results, in order, with their cycle numbers.
    always @(posedge clk) begin
        if (reset_n && res_valid && res_ready) begin
            acc_q.push_back(res_tag);
            acc_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        acc_q.delete();
        acc_cyc.delete();
        push_stalls = 0;
    endtask

    task automatic push(input logic [255:0] h);
        int   w;
        logic rdy;
        w        = 0;
        in_valid = 1'b1;
        in_H     = h;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            w++;
            if (w > 200) begin
                chk("push_timeout", 0, 1);
                break;
            end
        end
        #1;
        in_valid    = 1'b0;
        in_H        = '0;
        push_stalls += w;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 300) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic check_tags(input string name, input int n);
        chk({name, "_count"}, acc_q.size(), n);
        for (int i = 0; i < n && i < acc_q.size(); i++) begin
            chk({name, "_tag"}, acc_q[i], exp_q[i]);
        end
    endtask

    function automatic logic [255:0] pat(input int k);
        return {8{32'hC0DE_0000 + 32'(k)}};
    endfunction

    // ---------------- directed scenarios ----------------
    logic [255:0] h0;
    logic [255:0] q0_lit;
    logic [255:0] r0_lit;
    int           n_edges;

    initial begin
        n_pass        = 0;
        n_checks      = 0;
        cyc           = 0;
        in_valid      = 1'b0;
        in_H          = '0;
        res_ready     = 1'b1;
        qr_accept_out = 1'b1;
        force_nr      = 1'b0;
        h0            = {8{32'h0123_4567}};
        q0_lit        = {8{32'hFEDC_BA98}};
        r0_lit        = {8{32'h0123_4567}};

        // Reset values.
        do_reset();
        @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_qr_enable", qr_enable, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_sync, 0);
        @(posedge clk);
        #1;

        // Single job: result 7 edges after the push edge.
        push(h0);
        n_edges = 0;
        forever begin
            @(posedge clk);
            n_edges++;
            #1;
            if (res_valid || n_edges > 50) break;
        end
        chk("single_latency", n_edges, 7);
        chk("single_tag", res_tag, 0);
        chk("single_Q", res_Q, q0_lit);
        chk("single_R", res_R, r0_lit);
        @(posedge clk);
        #1;
        chk("single_drain_valid", res_valid, 0);
        chk("single_drain_busy", busy, 0);

        // Burst of 4 back-to-back.
        do_reset();
        exp_q = '{0, 1, 2, 3};
        for (int k = 0; k < 4; k++) push(pat(k));
        wait_idle();
        chk("burst_no_stall", push_stalls, 0);
        check_tags("burst", 4);
        for (int i = 1; i < acc_cyc.size(); i++) chk("burst_consec", acc_cyc[i] - acc_cyc[0], i);

        // Full FIFO with the core not accepting.
        do_reset();
        qr_accept_out = 1'b0;
        for (int k = 0; k < 4; k++) push(pat(10 + k));
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        fork
            push(pat(14));
            begin
                repeat (3) @(posedge clk);
                #1 qr_accept_out = 1'b1;
            end
        join
        chk("full_stalled", push_stalls >= 3, 1);
        wait_idle();
        exp_q = '{0, 1, 2, 3, 4};
        check_tags("full", 5);

        // Backpressure while 3 jobs are in flight.
        do_reset();
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) push(pat(20 + k));
        n_edges = 0;
        forever begin
            @(negedge clk);
            n_edges++;
            if (res_valid || n_edges > 50) break;
        end
        chk("bp_res_valid", res_valid, 1);
        chk("bp_enable_low", qr_enable, 0);
        repeat (5) @(negedge clk);
        chk("bp_hold_tag", res_tag, 0);
        chk("bp_hold_enable", qr_enable, 0);
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_idle();
        exp_q = '{0, 1, 2};
        check_tags("bp", 3);
        for (int i = 1; i < acc_cyc.size(); i++) chk("bp_consec", acc_cyc[i] - acc_cyc[0], i);

        // Tag wrap after 16 jobs.
        do_reset();
        for (int k = 0; k < 17; k++) push(pat(30 + k));
        wait_idle();
        chk("wrap_count", acc_q.size(), 17);
        if (acc_q.size() == 17) begin
            chk("wrap_tag15", acc_q[15], 15);
            chk("wrap_tag16", acc_q[16], 0);
        end

        // Sync error is sticky until reset.
        force_nr = 1'b1;
        push(pat(50));
        wait_idle();
        force_nr = 1'b0;
        chk("err_set", err_sync, 1);
        push(pat(51));
        wait_idle();
        chk("err_sticky", err_sync, 1);
        do_reset();
        @(negedge clk);
        chk("err_cleared", err_sync, 0);

        // Reset with 2 jobs in flight and 1 queued.
        @(posedge clk);
        #1;
        push(pat(60));
        push(pat(61));
        push(pat(62));
        qr_accept_out = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_enable", qr_enable, 1);
        chk("mid_rst_valid", res_valid, 0);
        @(posedge clk);
        #1;
        reset_n       = 1'b1;
        qr_accept_out = 1'b1;
        acc_q.delete();
        repeat (20) @(posedge clk);
        #1;
        chk("mid_no_results", acc_q.size(), 0);
        chk("mid_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/qr_job_scheduler.md
Name: qr_job_scheduler

Overview:
- Sequences the pipelined QR decomposition core (256-bit H in, 256-bit Q and R out) for the ZF detector.
- Buffers incoming channel matrices in a small FIFO and issues one per core accept slot.
- Tags every job and tracks it through the core pipeline with a shadow valid/tag shift register, so results leave with a valid bit and a sequence tag.
- Stalls the core (enable low) when the result sink applies backpressure, and flags any result-timing mismatch against the core's ready_out.

Parameters:
- DEPTH, 4, input FIFO depth in H matrices; power of two, at least 2.
- QR_LATENCY, 6, number of enabled core cycles from H sampled to Q/R presented with ready_out=1.
- TAG_W, 4, width of the job sequence tag.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream H matrix valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_H  in  256  H matrix (same packing as the core H_matrix).
- qr_enable  out  1  core enable.
- qr_accept_in  out  1  core output-accept; equals qr_enable.
- qr_accept_out  in  1  core can sample H this cycle.
- qr_ready_out  in  1  core Q/R valid this cycle.
- qr_H  out  256  H to core; FIFO head when issuing, else 0.
- qr_Q  in  256  core Q.
- qr_R  in  256  core R.
- res_valid  out  1  result register holds a valid job.
- res_ready  in  1  sink accepts the result.
- res_Q  out  256  registered Q.
- res_R  out  256  registered R.
- res_tag  out  TAG_W  tag of the result.
- busy  out  1  FIFO not empty, OR any valid in the shadow pipe, OR res_valid.
- err_sync  out  1  sticky: shadow tail valid while qr_ready_out=0.

Behaviour:
- Reset (async, any cycle including mid-job):
  - FIFO empty, tag counter 0, shadow pipe all invalid.
  - res_valid=0, res_Q/res_R/res_tag=0, err_sync=0, busy=0.
  - in_ready=1, qr_enable=1.
  - In-flight jobs are discarded, not replayed.
- Core contract:
  - The core samples qr_H on every cycle with qr_enable=1 and qr_accept_out=1.
  - Q/R appear QR_LATENCY enabled cycles later with qr_ready_out=1.
  - qr_ready_out and qr_accept_out do not depend combinationally on qr_enable.
- stall = res_valid & !res_ready; qr_enable = !stall (combinational).
- FIFO push: in_valid & in_ready.
  - No bypass: a word pushed at edge t is issuable from cycle t+1.
  - Full: in_ready=0 and in_H is ignored, even when a pop happens in the same cycle.
- Issue condition: qr_enable & qr_accept_out & FIFO not empty.
  - On issue: qr_H = head; pop at the edge; shadow entry {1, tag}; tag increments, wrapping 2^TAG_W-1 -> 0.
  - Otherwise: qr_H = 0; shadow entry {0, x} (bubble).
- Shadow pipe: QR_LATENCY stages of {valid, tag}.
  - Shifts only when qr_enable=1; holds when stalled.
  - With qr_accept_out=0 and qr_enable=1, a bubble is inserted.
- Result register:
  - Loads at an edge when qr_enable=1 and the shadow tail is valid: res_Q=qr_Q, res_R=qr_R, res_tag=tail tag, res_valid=1.
  - Clears when res_ready=1 and no load occurs.
  - Load and drain in the same cycle keeps res_valid=1 with the new data.
  - A bubble tail never loads.
- err_sync:
  - Sets at an edge where qr_enable=1, the tail is valid, and qr_ready_out=0.
  - The result is still loaded; only reset clears err_sync.
- Throughput: 1 job/cycle when accept_out=1 and res_ready=1.
- Minimum latency: push at edge t -> res_valid at edge t+1+QR_LATENCY.

Test Plan:
- Single job: reset; push H0 (DEPTH=4, QR_LATENCY=6), core model ideal, res_ready=1 -> res_valid rises 7 edges after the push, res_tag=0, res_Q/res_R match the model, busy falls the cycle after drain.
- Burst: push 4 matrices back-to-back with accept_out=1 -> in_ready stays 1; results emerge on consecutive cycles with tags 0,1,2,3.
- Full: hold accept_out=0 and push 5 matrices -> in_ready=0 after the 4th push; the 5th is accepted only after a pop; no job is lost or duplicated.
- Backpressure: res_ready=0 while 3 jobs are in flight -> qr_enable=0 from the cycle after the first load; the shadow pipe freezes; raising res_ready drains tags in order with no gaps.
- Tag wrap and sync check:
  - Issue 17 jobs with TAG_W=4 -> the 17th result has res_tag=0.
  - Force qr_ready_out=0 at an expected result cycle -> err_sync=1, held until reset.
- Reset mid-operation: assert reset_n=0 with 2 jobs in flight and 1 in the FIFO -> all outputs return to reset values immediately; no results appear after release.
